instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Encoder counterpart to the control unit's decode path: accepts field-level RV32I instruction descriptions and packs them into 32-bit instruction words.
- Writes packed words sequentially into instruction memory through a write port, so test programs load into the single-cycle core without hex files.
- Sits between a testbench or host sequencer and the instruction memory write port. Held in clear while the core runs.

Parameters:
ADDR_W, 8, word-address width of instruction memory write port
DEPTH, 256, number of words loadable before full (DEPTH <= 2**ADDR_W)
BASE, 0, first word address written after reset or clear

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
clear  input  1  synchronous: rewind write pointer to BASE, clear full/err/count
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept bundle this cycle
in_fmt  input  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
in_op  input  7  opcode field
in_funct3  input  3  funct3 (ignored for U/J)
in_funct7  input  7  funct7 (R only)
in_rd  input  5  destination register (R/I/U/J)
in_rs1  input  5  source 1 (R/I/S/B)
in_rs2  input  5  source 2 (R/S/B)
in_imm  input  32  immediate, byte-offset form (U: upper bits in [31:12])
mem_we  output  1  instruction memory write strobe
mem_addr  output  ADDR_W  word address for write
mem_wdata  output  32  encoded instruction word
count  output  ADDR_W+1  words written since reset/clear
full  output  1  DEPTH words written
err  output  1  sticky: illegal format accepted

Behaviour:
- Reset (rst low, async): mem_we=0, mem_addr=BASE, mem_wdata=0, count=0, full=0, err=0. in_ready=0 while rst low, 1 from first edge after release.
- Handshake: transfer when in_valid & in_ready on a rising edge. in_ready = !full & !clear.
- Throughput is one bundle per cycle.
- Latency: bundle accepted at edge N gives mem_we=1 with mem_addr/mem_wdata valid for exactly the cycle after edge N. Write pointer and count update at that same edge.
- Pipeline is one registered stage: encode combinationally, register word/addr/we.
- FSM states:
  - LOAD: accepting.
  - FULL: in_ready=0; entered on the edge that registers the DEPTH-th write.
  - clear in any state returns to LOAD.
- Encoding, standard RV32I bit placement:
  - R: {funct7, rs2, rs1, f3, rd, op}
  - I: {imm[11:0], rs1, f3, rd, op}
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}
  - U: {imm[31:12], rd, op}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}
  - Upper imm bits beyond the field are discarded, with no range check. imm[0] is ignored for B/J.
- Illegal fmt (6/7): bundle is consumed (handshake completes) but produces no write, no pointer or count change. err set next edge and held until clear or reset.
- Wrap-around: none. Pointer stops at BASE+DEPTH-1. full stays 1 until clear. in_valid while full is stalled, not dropped.
- clear and in_valid in same cycle: clear wins, bundle not accepted (in_ready=0).
  - Next edge: mem_addr=BASE, count=0, full=0, err=0, mem_we=0.
  - A write already registered in the output stage completes that cycle regardless.
- Reset mid-stream: any pending write is discarded (mem_we forced 0 immediately, asynchronously).

Test Plan:
- Reset release, then I-type op=0010011 f3=0 rd=1 rs1=0 imm=5 -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x00500093, count=1.
- Back-to-back bundles:
  - R add x3,x1,x2 (op 0110011, f7=0) -> 0x002081B3 @0
  - S sw x2,8(x1) (op 0100011, f3=2) -> 0x0020A423 @1
  - B beq x1,x2,imm=-4 (op 1100011) -> 0xFE208EE3 @2
  - U lui x5, imm=0x12345000 (op 0110111) -> 0x123452B7 @3
  - J jal x1, imm=8 (op 1101111) -> 0x008000EF @4
  - Writes occur on consecutive cycles; count=5.
- DEPTH=4: push 5 bundles continuously -> writes at 0..3, full=1 after 4th write, in_ready=0 and 5th held; assert clear -> full=0, next accepted bundle writes at address 0.
- fmt=6 between two legal bundles -> only two writes at addresses 0,1; err=1 from cycle after illegal accept, persists until clear.
- clear asserted with in_valid=1 -> no acceptance that cycle, count=0 next cycle; bundle accepted following cycle at BASE.
- rst pulled low one cycle after an accept -> mem_we drops to 0 asynchronously, no write; after release mem_addr=BASE, count=0.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Packs field-level RV32I instruction descriptions into 32-bit words and streams
// them into instruction memory at consecutive word addresses starting at BASE.
module instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int BASE   = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [2:0]        in_fmt_i,
  input  logic [6:0]        in_op_i,
  input  logic [2:0]        in_funct3_i,
  input  logic [6:0]        in_funct7_i,
  input  logic [4:0]        in_rd_i,
  input  logic [4:0]        in_rs1_i,
  input  logic [4:0]        in_rs2_i,
  input  logic [31:0]       in_imm_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              err_o
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);
  localparam logic [CNT_W-1:0]  LAST_C = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FULL
  } state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;

  logic              accept;
  logic              legal;
  logic              write;
  logic [31:0]       enc;

  assign legal  = (in_fmt_i < 3'd6);
  assign accept = in_valid_i & in_ready_o;
  assign write  = accept & legal;

  always_comb begin
    enc = '0;
    unique case (in_fmt_i)
      3'd0: enc = {in_funct7_i, in_rs2_i, in_rs1_i, in_funct3_i, in_rd_i, in_op_i};
      3'd1: enc = {in_imm_i[11:0], in_rs1_i, in_funct3_i, in_rd_i, in_op_i};
      3'd2: enc = {in_imm_i[11:5], in_rs2_i, in_rs1_i, in_funct3_i, in_imm_i[4:0], in_op_i};
      3'd3: enc = {in_imm_i[12], in_imm_i[10:5], in_rs2_i, in_rs1_i, in_funct3_i,
                   in_imm_i[4:1], in_imm_i[11], in_op_i};
      3'd4: enc = {in_imm_i[31:12], in_rd_i, in_op_i};
      3'd5: enc = {in_imm_i[20], in_imm_i[10:1], in_imm_i[11], in_imm_i[19:12], in_rd_i, in_op_i};
      default: enc = '0;
    endcase
  end

  // IDLE only exists so in_ready stays low until the first edge after reset release.
  always_comb begin
    state_d    = state_q;
    in_ready_o = 1'b0;
    unique case (state_q)
      ST_IDLE: state_d = ST_LOAD;
      ST_LOAD: begin
        in_ready_o = ~clear_i;
        if (write && (count_q == LAST_C)) state_d = ST_FULL;
      end
      ST_FULL: state_d = ST_FULL;
      default: state_d = ST_LOAD;
    endcase
    if (clear_i) state_d = ST_LOAD;
  end

  always_comb begin
    we_d    = write;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = err_q | (accept & ~legal);
    if (write) begin
      addr_d  = BASE_A + count_q[ADDR_W-1:0];
      wdata_d = enc;
      count_d = count_q + 1'b1;
    end
    if (clear_i) begin
      we_d    = 1'b0;
      addr_d  = BASE_A;
      count_d = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= BASE_A;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign count_o     = count_q;
  assign full_o      = (state_q == ST_FULL);
  assign err_o       = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: a default-depth instance for encoding
// and control checks, and a DEPTH=4 instance for the full/stall/clear behaviour.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rstN;
  logic        clear, clear4;
  logic        inValid, inValid4;
  logic        inReady, inReady4;
  logic [2:0]  inFmt;
  logic [6:0]  inOp;
  logic [2:0]  inF3;
  logic [6:0]  inF7;
  logic [4:0]  inRd, inRs1, inRs2;
  logic [31:0] inImm;

  logic        memWe, memWe4;
  logic [7:0]  memAddr, memAddr4;
  logic [31:0] memWdata, memWdata4;
  logic [8:0]  count, count4;
  logic        full, full4, err, err4;

  int numCompared   = 0;
  int numMismatched = 0;

  always #5 clk = ~clk;

  instr_encoder_loader dut (
    .clk_i(clk), .rst_ni(rstN), .clear_i(clear),
    .in_valid_i(inValid), .in_ready_o(inReady),
    .in_fmt_i(inFmt), .in_op_i(inOp), .in_funct3_i(inF3), .in_funct7_i(inF7),
    .in_rd_i(inRd), .in_rs1_i(inRs1), .in_rs2_i(inRs2), .in_imm_i(inImm),
    .mem_we_o(memWe), .mem_addr_o(memAddr), .mem_wdata_o(memWdata),
    .count_o(count), .full_o(full), .err_o(err)
  );

  instr_encoder_loader #(.ADDR_W(8), .DEPTH(4), .BASE(0)) dut4 (
    .clk_i(clk), .rst_ni(rstN), .clear_i(clear4),
    .in_valid_i(inValid4), .in_ready_o(inReady4),
    .in_fmt_i(inFmt), .in_op_i(inOp), .in_funct3_i(inF3), .in_funct7_i(inF7),
    .in_rd_i(inRd), .in_rs1_i(inRs1), .in_rs2_i(inRs2), .in_imm_i(inImm),
    .mem_we_o(memWe4), .mem_addr_o(memAddr4), .mem_wdata_o(memWdata4),
    .count_o(count4), .full_o(full4), .err_o(err4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numCompared++;
    if (got !== exp) begin
      numMismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] imm);
    inFmt = fmt; inOp = op; inF3 = f3; inF7 = f7;
    inRd = rd; inRs1 = rs1; inRs2 = rs2; inImm = imm;
    inValid = 1'b1;
  endtask

  task automatic pulseClear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rstN = 1'b0; clear = 1'b0; clear4 = 1'b0; inValid = 1'b0; inValid4 = 1'b0;
    inFmt = '0; inOp = '0; inF3 = '0; inF7 = '0; inRd = '0; inRs1 = '0; inRs2 = '0; inImm = '0;

    #1;
    checkOutput("rst_we",    memWe,    0);
    checkOutput("rst_addr",  memAddr,  0);
    checkOutput("rst_wdata", memWdata, 0);
    checkOutput("rst_count", count,    0);
    checkOutput("rst_full",  full,     0);
    checkOutput("rst_err",   err,      0);
    checkOutput("rst_ready", inReady,  0);

    @(negedge clk);
    rstN = 1'b1;
    #1 checkOutput("ready_before_edge", inReady, 0);
    @(negedge clk);
    checkOutput("ready_after_edge", inReady, 1);

    // addi x1, x0, 5
    applyStimulus(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    @(negedge clk);
    inValid = 1'b0;
    checkOutput("i_we",    memWe,    1);
    checkOutput("i_addr",  memAddr,  0);
    checkOutput("i_wdata", memWdata, 32'h00500093);
    checkOutput("i_count", count,    1);
    @(negedge clk);
    checkOutput("i_we_drop", memWe, 0);

    pulseClear();
    checkOutput("clr_count", count, 0);

    applyStimulus(3'd0, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    @(negedge clk);
    checkOutput("r_we", memWe, 1);
    checkOutput("r_addr", memAddr, 0);
    checkOutput("r_wdata", memWdata, 32'h002081B3);
    applyStimulus(3'd2, 7'b0100011, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    @(negedge clk);
    checkOutput("s_we", memWe, 1);
    checkOutput("s_addr", memAddr, 1);
    checkOutput("s_wdata", memWdata, 32'h0020A423);
    applyStimulus(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
    @(negedge clk);
    checkOutput("b_we", memWe, 1);
    checkOutput("b_addr", memAddr, 2);
    checkOutput("b_wdata", memWdata, 32'hFE208EE3);
    applyStimulus(3'd4, 7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
    @(negedge clk);
    checkOutput("u_we", memWe, 1);
    checkOutput("u_addr", memAddr, 3);
    checkOutput("u_wdata", memWdata, 32'h123452B7);
    applyStimulus(3'd5, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8);
    @(negedge clk);
    inValid = 1'b0;
    checkOutput("j_we", memWe, 1);
    checkOutput("j_addr", memAddr, 4);
    checkOutput("j_wdata", memWdata, 32'h008000EF);
    checkOutput("b2b_count", count, 5);
    @(negedge clk);
    checkOutput("b2b_we_drop", memWe, 0);

    // Illegal format sandwiched between two legal bundles
    pulseClear();
    applyStimulus(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    @(negedge clk);
    checkOutput("ill_first_addr", memAddr, 0);
    applyStimulus(3'd6, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd7);
    @(negedge clk);
    checkOutput("ill_we", memWe, 0);
    checkOutput("ill_err", err, 1);
    checkOutput("ill_count", count, 1);
    applyStimulus(3'd0, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    @(negedge clk);
    inValid = 1'b0;
    checkOutput("ill_second_we", memWe, 1);
    checkOutput("ill_second_addr", memAddr, 1);
    checkOutput("ill_count2", count, 2);
    @(negedge clk);
    checkOutput("ill_err_sticky", err, 1);
    pulseClear();
    checkOutput("ill_err_cleared", err, 0);

    // clear wins over a simultaneous valid bundle
    applyStimulus(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd9);
    @(negedge clk);
    applyStimulus(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd10);
    clear = 1'b1;
    #1 checkOutput("cv_ready", inReady, 0);
    @(negedge clk);
    clear = 1'b0;
    checkOutput("cv_count", count, 0);
    checkOutput("cv_we", memWe, 0);
    @(negedge clk);
    inValid = 1'b0;
    checkOutput("cv_acc_we", memWe, 1);
    checkOutput("cv_acc_addr", memAddr, 0);
    checkOutput("cv_acc_wdata", memWdata, 32'h00A00113);

    // Reset mid-stream discards the registered write
    applyStimulus(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd3);
    @(negedge clk);
    inValid = 1'b0;
    checkOutput("rs_pre_addr", memAddr, 1);
    rstN = 1'b0;
    #1;
    checkOutput("rs_we_async", memWe, 0);
    checkOutput("rs_addr_async", memAddr, 0);
    checkOutput("rs_count_async", count, 0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("rs_ready", inReady, 1);
    checkOutput("rs_addr", memAddr, 0);
    checkOutput("rs_count", count, 0);

    // DEPTH=4 instance: five continuous bundles, fifth stalls until clear
    for (int k = 0; k < 4; k++) begin
      applyStimulus(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'(k));
      inValid = 1'b0;
      inValid4 = 1'b1;
      @(negedge clk);
      checkOutput($sformatf("d4_we%0d", k), memWe4, 1);
      checkOutput($sformatf("d4_addr%0d", k), memAddr4, 32'(k));
      checkOutput($sformatf("d4_wdata%0d", k), memWdata4, (32'(k) << 20) | 32'h93);
    end
    applyStimulus(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4);
    inValid = 1'b0;
    checkOutput("d4_full", full4, 1);
    checkOutput("d4_ready_full", inReady4, 0);
    checkOutput("d4_count", count4, 4);
    @(negedge clk);
    checkOutput("d4_stall_we", memWe4, 0);
    checkOutput("d4_stall_addr", memAddr4, 3);
    checkOutput("d4_still_full", full4, 1);
    clear4 = 1'b1;
    @(negedge clk);
    clear4 = 1'b0;
    checkOutput("d4_clr_full", full4, 0);
    checkOutput("d4_clr_count", count4, 0);
    @(negedge clk);
    inValid4 = 1'b0;
    checkOutput("d4_held_we", memWe4, 1);
    checkOutput("d4_held_addr", memAddr4, 0);
    checkOutput("d4_held_wdata", memWdata4, 32'h00400093);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
